// File: rtl/set_bit_scanner.sv
// Sequential set-bit scanner: captures a vector and hands out the index of
// each set bit, lowest first, one per accepted beat, then pulses done.
//
// Handshake: valid is high for the whole SCAN state and index is stable
// while valid=1 and ack=0; a beat transfers on a rising edge where
// valid=1 and ack=1. ack is ignored whenever valid=0.
module set_bit_scanner #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] vec,
    input  logic         ack,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] index,
    output logic [W:0]   count,
    output logic         done,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] mask_q, mask_d;
    logic [W:0]   count_q, count_d;
    logic [N-1:0] mask_cleared;
    logic [W-1:0] lowest_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    // Priority encoder: descending loop so the lowest set bit wins.
    always_comb begin
        lowest_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lowest_idx = W'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit.
    assign mask_cleared = mask_q & (mask_q - N'(1));

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = vec;
                    count_d = '0;
                    state_d = (|vec) ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                if (ack) begin
                    mask_d  = mask_cleared;
                    count_d = count_q + (W + 1)'(1);
                    if (~|mask_cleared) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign valid     = (state_q == S_SCAN);
    assign done      = (state_q == S_DONE);
    assign index     = lowest_idx;
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_set_bit_scanner.sv
// Self-checking bench for set_bit_scanner at N=8: table of directed scans,
// hand-written reset/restart sequences and randomized scans against a model.
module tb_set_bit_scanner;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] vec;
    logic         ack;
    logic         busy;
    logic         valid;
    logic [W-1:0] index;
    logic [W:0]   count;
    logic         done;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    set_bit_scanner #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec       (vec),
        .ack       (ack),
        .busy      (busy),
        .valid     (valid),
        .index     (index),
        .count     (count),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_valid"}, 64'(valid), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_count"}, 64'(count), 0);
        chk({tag, "_index"}, 64'(index), 0);
    endtask

    // mode 0: ack always high; 1: random ack; 2: ack low for 4 cycles, then high.
    // poke drives start with poke_vec throughout SCAN and during the DONE pulse.
    task automatic run_scan(input logic [N-1:0] v, input int mode, input logic poke,
                            input logic [N-1:0] poke_vec, output int got_count,
                            output int got_first);
        logic [W-1:0] exp_q[$];
        int accepted;
        int cyc;
        int pc;
        exp_q = {};
        for (int i = 0; i < N; i++) begin
            if (v[i]) exp_q.push_back(W'(i));
        end
        pc        = exp_q.size();
        got_first = -1;
        start = 1'b1;
        vec   = v;
        ack   = 1'b0;
        step();
        start    = 1'b0;
        accepted = 0;
        cyc      = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            chk("scan_valid", 64'(valid), 1);
            chk("scan_busy", 64'(busy), 1);
            chk("scan_done", 64'(done), 0);
            chk("scan_index", 64'(index), 64'(exp_q[0]));
            chk("scan_count", 64'(count), 64'(accepted));
            if (got_first < 0) got_first = int'(index);
            case (mode)
                0:       ack = 1'b1;
                1:       ack = 1'($urandom_range(0, 1));
                default: ack = (cyc >= 4);
            endcase
            start = poke;
            vec   = poke ? poke_vec : N'($urandom);
            step();
            cyc++;
            if (ack) begin
                void'(exp_q.pop_front());
                accepted++;
            end
        end
        chk("scan_timeout", 64'(exp_q.size()), 0);
        chk("done_pulse", 64'(done), 1);
        chk("done_valid", 64'(valid), 0);
        chk("done_busy", 64'(busy), 1);
        chk("done_count", 64'(count), 64'(pc));
        got_count = int'(count);
        ack   = 1'b0;
        start = poke;
        vec   = poke_vec;
        step();
        chk("idle_busy", 64'(busy), 0);
        chk("idle_done", 64'(done), 0);
        chk("idle_valid", 64'(valid), 0);
        chk("idle_count_held", 64'(count), 64'(pc));
        start = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] v;
        int           mode;
        int           exp_count;
        int           exp_first;
    } vec_rec_t;

    vec_rec_t tbl[7];

    initial begin
        int gc;
        int gf;
        logic [N-1:0] rv;

        tbl[0] = '{8'hA4, 0, 3, 2};
        tbl[1] = '{8'h18, 2, 2, 3};
        tbl[2] = '{8'h00, 0, 0, -1};
        tbl[3] = '{8'hFF, 0, 8, 0};
        tbl[4] = '{8'h80, 0, 1, 7};
        tbl[5] = '{8'h01, 1, 1, 0};
        tbl[6] = '{8'h5A, 1, 4, 1};

        rst   = 1'b0;
        start = 1'b0;
        vec   = '0;
        ack   = 1'b0;
        #3 rst = 1'b1;
        #1 chk_quiet("rst_held");
        #8 rst = 1'b0;
        step();
        chk_quiet("after_rst");

        for (int t = 0; t < 7; t++) begin
            run_scan(tbl[t].v, tbl[t].mode, 1'b0, '0, gc, gf);
            chk("tbl_count", 64'(gc), 64'(tbl[t].exp_count));
            chk("tbl_first", 64'(gf), 64'(tbl[t].exp_first));
        end

        // start with a different vector during SCAN and DONE must be ignored
        run_scan(8'h81, 0, 1'b1, 8'h7E, gc, gf);
        chk("ignore_count", 64'(gc), 2);
        step();
        chk("ignore_no_restart", 64'(busy), 0);

        // reset in the middle of a scan after indices 4 and 5 are accepted
        start = 1'b1;
        vec   = 8'hF0;
        step();
        start = 1'b0;
        ack   = 1'b1;
        step();
        step();
        chk("mid_index", 64'(index), 6);
        chk("mid_count", 64'(count), 2);
        rst = 1'b1;
        #1 chk_quiet("mid_rst");
        #2 rst = 1'b0;
        ack = 1'b0;
        step();
        chk_quiet("mid_rst_release");
        run_scan(8'h02, 0, 1'b0, '0, gc, gf);
        chk("post_rst_first", 64'(gf), 1);
        chk("post_rst_count", 64'(gc), 1);

        for (int r = 0; r < 25; r++) begin
            rv = N'($urandom_range(0, 255));
            run_scan(rv, 1, 1'($urandom_range(0, 1)), N'($urandom), gc, gf);
            chk("rand_popcount", 64'(gc), 64'($countones(rv)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/set_bit_scanner.md
# set_bit_scanner

Sequential companion to the N-input OR reduction. The OR collapses a vector into one "any bit set" flag; this block does the reverse. It takes a captured N-bit vector and returns the index of every set bit, lowest first, one per handshake. It then signals completion once the remaining-bit mask reduces to zero. Typical use is request vectors, interrupt lines, or bitmap free-lists feeding downstream logic that needs bit positions rather than a flag.

## Interface
- N, default 8, vector width; legal range 2..64.
- W, default $clog2(N), index width; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  capture `vec` and begin a scan; honoured only in IDLE.
- vec  input  N  vector to scan; sampled only on an accepted start.
- ack  input  1  consumer accepts the current index; meaningful only while `valid`=1.
- busy  output  1  high in SCAN and DONE states.
- valid  output  1  `index` holds a set-bit position.
- index  output  W  position of the lowest set bit still in the mask.
- count  output  W+1  number of indices accepted so far in this scan.
- done  output  1  one-cycle pulse marking the end of the scan.

## Operation
- Internal registers: `mask` (N bits), `count` (W+1 bits), state in {IDLE, SCAN, DONE}.
- Reset (asynchronous, any state): state=IDLE, mask=0, count=0. All outputs are 0 while rst is high and after release.
- IDLE:
  - start=1 with vec≠0: mask←vec, count←0, go to SCAN.
  - start=1 with vec=0: mask←0, count←0, go to DONE (empty scan; no valid is ever raised).
  - start=0: stay in IDLE.
- SCAN:
  - valid=1.
  - index = position of the lowest 1 in mask. This is combinational priority logic from mask, not registered separately.
  - On ack=1: clear that bit in mask and increment count.
    - If the cleared mask is all-zero (OR-reduce of the next mask =0), go to DONE.
    - Otherwise stay in SCAN.
  - On ack=0: hold mask, index and count stable.
- DONE:
  - done=1 and valid=0 for exactly one cycle.
  - count holds the final popcount of the captured vec.
  - Go to IDLE unconditionally.
- start is ignored in SCAN and DONE; there is no queuing or restart mid-scan.
- vec changes after capture have no effect.
- count is held in IDLE until the next accepted start, which zeroes it.
- busy = (state≠IDLE).
- Outputs derived from registered state: valid, done and busy are registered-state decodes with no combinational path from start.
- Combinational paths: index depends only on mask. The only input-to-output combinational path is none; ack affects outputs only at the next edge.

## Timing
- Start accepted at edge k: busy=1 and valid=1 from cycle k+1, showing the lowest set bit.
- Throughput: one index per cycle when ack is held high.
  - A vector with P set bits gives valid high for P consecutive cycles.
  - done rises at cycle k+P+1.
  - busy falls at cycle k+P+2.
- Empty vec: done=1 at cycle k+1, busy falls at k+2, valid never asserts.
- An ack held low stretches SCAN indefinitely with all outputs frozen.
- Full vector (all N bits set): count ends at N, which needs W+1 bits; it must not wrap.
- Single bit at position N-1: index=N-1 for one accepted beat, then done.
- Reset asserted mid-scan: all outputs drop asynchronously. The next cycle after release is IDLE, and a fresh start is accepted normally.
- start asserted in the same cycle as the DONE pulse is ignored. The earliest accepted restart is the first IDLE cycle.

## Test plan
- Reset and idle check.
  - Stimulus: rst pulsed mid-cycle, then released with start=0.
  - Required: busy=valid=done=0, count=0, index=0.
- Typical scan at N=8.
  - Stimulus: vec=8'b1010_0100, start for one cycle, ack held at 1.
  - Required: index sequence 2, 5, 7 on three consecutive valid cycles; done one cycle later; count=3.
- Backpressure at N=8.
  - Stimulus: vec=8'b0001_1000, ack=0 for 4 cycles, then ack=1.
  - Required: index=3 held stable for 4 cycles, then 4, then done; count=2.
- Empty and full vectors at N=8.
  - Stimulus 1: vec=0. Required: done one cycle after start, valid never high, count=0.
  - Stimulus 2: vec=8'hFF. Required: indices 0..7 consecutively, count=8 with no wrap.
- Start ignored while busy.
  - Stimulus: vec=8'h81 accepted; during SCAN apply start with vec=8'h7E.
  - Required: only indices 0 and 7 appear; 8'h7E is never scanned.
- Reset mid-scan.
  - Stimulus: vec=8'hF0, rst asserted after index 5 is accepted; after release, start with vec=8'h02.
  - Required: outputs clear immediately on rst; the new scan yields index 1, count=1, then done.
